// File: rtl/zero_indices_resp_buffer.sv
// Response FIFO between the zero-index scanner and its consumer.
// Holds {last, index} entries and back-pressures the scanner via en.
module zero_indices_resp_buffer #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_resp_valid,
  input  logic [$clog2(W)-1:0]       in_resp_index,
  input  logic                       in_final,
  output logic                       en,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(W)-1:0]       out_index,
  output logic                       out_last,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int IDX_W = $clog2(W);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [IDX_W:0]     mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   count;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;

  always_comb begin
    full  = (count == CNT_W'(DEPTH));
    empty = (count == '0);
    // en depends only on registered state and flush/rst, never on out_ready
    en    = ~rst & ~flush & ~full;
    push  = in_resp_valid & en;
    out_valid = ~empty;
    pop   = out_valid & out_ready;
    out_index = mem[rd_ptr][IDX_W-1:0];
    out_last  = mem[rd_ptr][IDX_W];
    occupancy = count;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Payload storage carries no reset; contents are don't-care while empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_final, in_resp_index};
  end

endmodule

// File: tb/tb_zero_indices_resp_buffer.sv
// Self-checking bench for zero_indices_resp_buffer (W=8, DEPTH=4) using a
// queue-based reference model and a behavioural zero-index scanner.
module tb_zero_indices_resp_buffer;

  localparam int W     = 8;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_resp_valid;
  logic [2:0] in_resp_index;
  logic       in_final;
  logic       en;
  logic       flush;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_index;
  logic       out_last;
  logic [2:0] occupancy;

  zero_indices_resp_buffer #(.W(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_resp_valid(in_resp_valid),
    .in_resp_index(in_resp_index), .in_final(in_final), .en(en),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_index(out_index), .out_last(out_last), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  int unsigned compared = 0;
  int unsigned mismatched = 0;

  logic [7:0] vec;            // scanner's remaining vector: 0 bits are pending zeros
  logic [3:0] q[$];           // model FIFO contents {last, index}
  logic [3:0] popped[$];      // entries delivered to the consumer

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int lowest_zero(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (!v[i]) return i;
    return -1;
  endfunction

  // One clock cycle: drive inputs, check against model, advance model at the edge.
  task automatic cycle(input logic r, input logic f, input logic rdy);
    int   lz;
    logic exp_en, exp_push, exp_pop;
    lz            = lowest_zero(vec);
    rst           = r;
    flush         = f;
    out_ready     = rdy;
    in_resp_valid = (lz >= 0);
    in_resp_index = (lz >= 0) ? 3'(lz) : 3'($urandom_range(0, 7));
    in_final      = ($countones(~vec) == 1) ? 1'b1 : 1'b0;
    exp_en  = !r && !f && (q.size() < DEPTH);
    exp_push = in_resp_valid && exp_en;
    exp_pop  = !r && !f && (q.size() > 0) && rdy;
    @(negedge clk);
    chk("en", 32'(en), 32'(exp_en));
    chk("occupancy", 32'(occupancy), 32'(q.size()));
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      chk("out_index", 32'(out_index), 32'(q[0][2:0]));
      chk("out_last", 32'(out_last), 32'(q[0][3]));
    end
    @(posedge clk);
    if (r || f) q.delete();
    else begin
      if (exp_pop) popped.push_back(q.pop_front());
      if (exp_push) q.push_back({in_final, in_resp_index});
    end
    if (exp_push) vec[lz] = 1'b1;
    #1;
  endtask

  initial begin
    vec = 8'hFF;
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    in_resp_valid = 1'b0; in_resp_index = '0; in_final = 1'b0;
    @(posedge clk); #1;
    cycle(1'b1, 1'b0, 1'b0);   // reset state check
    cycle(1'b0, 1'b0, 1'b0);

    // Sparse vector, consumer always ready: 0,3,4,6 with last only on 6
    popped.delete();
    vec = 8'b1010_0110;
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 1'b1);
    chk("seq1_len", 32'(popped.size()), 32'd4);
    if (popped.size() == 4) begin
      chk("seq1_0", 32'(popped[0]), 32'h0);
      chk("seq1_1", 32'(popped[1]), 32'h3);
      chk("seq1_2", 32'(popped[2]), 32'h4);
      chk("seq1_3", 32'(popped[3]), 32'hE);
    end

    // All zeros with stalled consumer: fill, stall, then drain (pop while full)
    popped.delete();
    vec = 8'h00;
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b0);
    chk("full_occ", 32'(occupancy), 32'd4);
    for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, 1'b1);
    chk("seq2_len", 32'(popped.size()), 32'd8);
    for (int i = 0; i < 8 && i < popped.size(); i++)
      chk("seq2", 32'(popped[i]), (i == 7) ? 32'hF : 32'(i));

    // Three entries stored, then flush with consumer ready
    vec = 8'h00;
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0);
    chk("pre_flush_occ", 32'(occupancy), 32'd3);
    cycle(1'b0, 1'b1, 1'b1);
    chk("post_flush_occ", 32'(occupancy), 32'd0);
    chk("post_flush_vec", 32'(vec), 32'h07);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b1);

    // Reset mid-operation with two entries stored and scanner valid
    vec = 8'h00;
    for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    vec = 8'hFF;

    // No zeros: nothing pushed
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1);
    chk("ff_occ", 32'(occupancy), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      if (vec == 8'hFF && $urandom_range(0, 2) == 0) vec = 8'($urandom);
      cycle(($urandom_range(0, 59) == 0), ($urandom_range(0, 39) == 0),
            ($urandom_range(0, 3) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
